// File: rtl/mem_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_pkg
// Purpose  : Shared widths and enums for the memory-port arbiter slice.
// Revision : 1.0  initial release
// ============================================================================
package mem_pkg;

    localparam int LINE_W = 128;
    localparam int ADDR_W = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } arb_state_t;

    typedef enum logic {
        REQ_I = 1'b0,
        REQ_D = 1'b1
    } req_id_t;

endpackage
`default_nettype wire

// File: rtl/mem_port_arbiter_rr_pick2.sv
`default_nettype none
// ============================================================================
// Module   : rr_pick2
// Purpose  : Combinational two-way picker, round-robin or fixed D priority.
// Revision : 1.0  initial release
// ============================================================================
module rr_pick2
    import mem_pkg::*;
(
    input  logic    req_i,
    input  logic    req_d,
    input  req_id_t last_grant,
    input  logic    fixed_prio,
    output req_id_t grant_id,
    output logic    grant_valid
);

    always_comb begin
        grant_valid = req_i | req_d;
        grant_id    = REQ_I;
        if (req_i && req_d) begin
            // On a tie the side that did not win last time goes next.
            grant_id = (fixed_prio || (last_grant == REQ_I)) ? REQ_D : REQ_I;
        end else if (req_d) begin
            grant_id = REQ_D;
        end
    end

endmodule
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter
// Purpose  : Shares one main-memory line port between I- and D-cache misses.
// Revision : 1.0  initial release
// ============================================================================
module mem_port_arbiter
    import mem_pkg::*;
#(
    parameter int FIXED_PRIO     = 0,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              in_i_req,
    input  logic              in_i_write,
    input  logic [ADDR_W-1:0] in_i_addr,
    input  logic [LINE_W-1:0] in_i_wdata,
    output logic [LINE_W-1:0] out_i_rdata,
    output logic              out_i_ready,

    input  logic              in_d_req,
    input  logic              in_d_write,
    input  logic [ADDR_W-1:0] in_d_addr,
    input  logic [LINE_W-1:0] in_d_wdata,
    output logic [LINE_W-1:0] out_d_rdata,
    output logic              out_d_ready,

    output logic              out_mem_read_en,
    output logic              out_mem_write_en,
    output logic [ADDR_W-1:0] out_mem_addr,
    output logic [LINE_W-1:0] out_mem_write_data,
    input  logic [LINE_W-1:0] in_mem_read_data,
    input  logic              in_mem_ready,

    output logic              out_busy,
    output logic              out_timeout_err
);

    localparam int               WD_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WD_W-1:0]  WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

    arb_state_t        state_q, state_d;
    req_id_t           owner_q, owner_d;
    req_id_t           last_grant_q, last_grant_d;
    logic              write_q, write_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LINE_W-1:0] wdata_q, wdata_d;
    logic [LINE_W-1:0] i_rdata_q, i_rdata_d;
    logic [LINE_W-1:0] d_rdata_q, d_rdata_d;
    logic [WD_W-1:0]   wd_q, wd_d;
    logic              err_q, err_d;

    req_id_t           pick_id;
    logic              pick_valid;
    logic              rd_load;
    logic [LINE_W-1:0] rd_line;

    rr_pick2 u_pick (
        .req_i       (in_i_req),
        .req_d       (in_d_req),
        .last_grant  (last_grant_q),
        .fixed_prio  (FIXED_PRIO != 0),
        .grant_id    (pick_id),
        .grant_valid (pick_valid)
    );

    always_comb begin
        state_d          = state_q;
        owner_d          = owner_q;
        last_grant_d     = last_grant_q;
        write_d          = write_q;
        addr_d           = addr_q;
        wdata_d          = wdata_q;
        i_rdata_d        = i_rdata_q;
        d_rdata_d        = d_rdata_q;
        wd_d             = wd_q;
        err_d            = err_q;
        rd_load          = 1'b0;
        rd_line          = '0;
        out_mem_read_en  = 1'b0;
        out_mem_write_en = 1'b0;
        out_i_ready      = 1'b0;
        out_d_ready      = 1'b0;

        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    state_d      = BUSY;
                    owner_d      = pick_id;
                    last_grant_d = pick_id;
                    write_d      = (pick_id == REQ_D) ? in_d_write : in_i_write;
                    addr_d       = (pick_id == REQ_D) ? in_d_addr  : in_i_addr;
                    wdata_d      = (pick_id == REQ_D) ? in_d_wdata : in_i_wdata;
                    wd_d         = '0;
                end
            end
            BUSY: begin
                // Enables fall in the ready cycle so memory never sees a restart.
                out_mem_read_en  = ~write_q & ~in_mem_ready;
                out_mem_write_en =  write_q & ~in_mem_ready;
                if (in_mem_ready) begin
                    state_d = RESP;
                    rd_load = ~write_q;
                    rd_line = in_mem_read_data;
                end else if (wd_q == WD_LAST) begin
                    state_d = RESP;
                    err_d   = 1'b1;
                    rd_load = ~write_q;
                end else begin
                    wd_d = wd_q + WD_W'(1);
                end
            end
            RESP: begin
                out_i_ready = (owner_q == REQ_I);
                out_d_ready = (owner_q == REQ_D);
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (rd_load) begin
            if (owner_q == REQ_D) begin
                d_rdata_d = rd_line;
            end else begin
                i_rdata_d = rd_line;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            owner_q      <= REQ_I;
            last_grant_q <= REQ_I;
            write_q      <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            i_rdata_q    <= '0;
            d_rdata_q    <= '0;
            wd_q         <= '0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            write_q      <= write_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            i_rdata_q    <= i_rdata_d;
            d_rdata_q    <= d_rdata_d;
            wd_q         <= wd_d;
            err_q        <= err_d;
        end
    end

    assign out_i_rdata        = i_rdata_q;
    assign out_d_rdata        = d_rdata_q;
    assign out_mem_addr       = addr_q;
    assign out_mem_write_data = wdata_q;
    assign out_busy           = (state_q != IDLE);
    assign out_timeout_err    = err_q;

endmodule
`default_nettype wire
